// File: rtl/result_display_scan_if.sv
// Signal bundle between the mycpu result/status outputs and the display scan stage.
// The master drives the CPU-side inputs; the slave (display stage) drives the pins.
interface result_display_scan_if #(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] result;
  logic [2:0]        stage;
  logic [7:0]        mAddr;
  logic              freeze;
  logic [7:0]        b2d;
  logic [3:0]        an;
  logic [7:0]        leds;

  modport master (
    output result, stage, mAddr, freeze,
    input  b2d, an, leds
  );

  modport slave (
    input  result, stage, mAddr, freeze,
    output b2d, an, leds
  );
endinterface

// File: rtl/result_display_scan.sv
// Captures the CPU result on write-back entry and scans it as four hex digits onto a
// common-anode 7-segment display; also mirrors stage/mAddr onto the board LEDs.
module result_display_scan #(
  parameter int         WORD_W      = 16,
  parameter int         REFRESH_DIV = 50000,
  parameter logic [2:0] WB_STAGE    = 3'd4,
  parameter int         NEW_HOLD    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  result_display_scan_if.slave bus
);

  localparam int              DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam int              NEW_W    = $clog2(NEW_HOLD * 4 + 1);
  localparam logic [NEW_W-1:0] NEW_LOAD = NEW_W'(NEW_HOLD * 4);

  logic [15:0]      cap_reg;
  logic [2:0]       stage_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [1:0]       digit_reg;
  logic [NEW_W-1:0] new_cnt_reg;
  logic [7:0]       b2d_reg;
  logic [3:0]       an_reg;
  logic [7:0]       leds_reg;

  logic [15:0] res16;
  logic        capture;
  logic        tick;
  logic [1:0]  digit_next;
  logic [6:0]  seg_next;
  logic        dp_n_next;
  logic [3:0]  nib [4];

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Narrow result words are zero-extended so the upper digits read 0.
  generate
    if (WORD_W >= 16) begin : g_res_wide
      assign res16 = bus.result[15:0];
    end else begin : g_res_narrow
      assign res16 = {{(16 - WORD_W){1'b0}}, bus.result};
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = cap_reg[4*gi+3 -: 4];
    end
  endgenerate

  always_comb begin
    capture    = (bus.stage == WB_STAGE) && (stage_reg != WB_STAGE) && !bus.freeze;
    tick       = (div_cnt_reg == DIV_LAST);
    digit_next = digit_reg + 2'd1;
    seg_next   = hex_seg(nib[digit_next]);
    dp_n_next  = !((digit_next == 2'd0) && (new_cnt_reg != '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_reg     <= '0;
      stage_reg   <= '0;
      div_cnt_reg <= '0;
      digit_reg   <= '0;
      new_cnt_reg <= '0;
      b2d_reg     <= 8'hFF;
      an_reg      <= 4'hF;
      leds_reg    <= '0;
    end else begin
      stage_reg   <= bus.stage;
      leds_reg    <= {bus.stage, bus.mAddr[4:0]};
      div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
      if (capture)
        cap_reg <= res16;
      // Display pins only move on slot boundaries, so a capture shows at the next tick.
      if (tick) begin
        digit_reg <= digit_next;
        an_reg    <= ~(4'b0001 << digit_next);
        b2d_reg   <= {dp_n_next, seg_next};
      end
      // A fresh capture restarts the dp hold rather than extending it.
      if (capture)
        new_cnt_reg <= NEW_LOAD;
      else if (tick && (new_cnt_reg != '0))
        new_cnt_reg <= new_cnt_reg - 1'b1;
    end
  end

  assign bus.b2d  = b2d_reg;
  assign bus.an   = an_reg;
  assign bus.leds = leds_reg;

endmodule
